// File: rtl/compositor_pkg.sv
// Shared types and constants for the N-layer pixel compositor.
package compositor_pkg;

    localparam int CFG_COORD_W        = 10;
    localparam int CFG_ADDR_W         = 19;
    localparam int PIPE_LAT           = 3;
    localparam int TRANSP_IDX_DEFAULT = 0;

    typedef struct packed {
        logic [CFG_COORD_W-1:0] x;
        logic [CFG_COORD_W-1:0] y;
        logic [CFG_COORD_W-1:0] w;
        logic [CFG_COORD_W-1:0] h;
        logic [CFG_COORD_W-1:0] stride;
        logic [CFG_COORD_W-1:0] scroll;
        logic [CFG_ADDR_W-1:0]  base;
        logic                   en;
        logic                   wrap;
    } layer_cfg_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/layer_addr_gen.sv
// Address stage for one layer: box test plus RAM address, registered on pix_en.
module layer_addr_gen
    import compositor_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_en,
    input  logic [CFG_COORD_W-1:0] draw_x,
    input  logic [CFG_COORD_W-1:0] draw_y,
    input  layer_cfg_t             cfg,
    output logic [CFG_ADDR_W-1:0]  rd_addr,
    output logic                   in_box
);

    localparam int SW = CFG_COORD_W + 1;

    logic signed [SW-1:0] rx_direct;
    logic signed [SW-1:0] ry;
    logic signed [SW-1:0] rx;
    logic [SW-1:0] wsum0;
    logic [SW-1:0] wsum1;
    logic [SW-1:0] wsum2;
    logic [SW-1:0] w_ext;
    logic [SW-1:0] h_ext;
    logic          in_box_c;
    logic [CFG_ADDR_W-1:0] addr_c;

    always_comb begin
        w_ext     = {1'b0, cfg.w};
        h_ext     = {1'b0, cfg.h};
        rx_direct = $signed({1'b0, draw_x}) - $signed({cfg.x[CFG_COORD_W-1], cfg.x});
        ry        = $signed({1'b0, draw_y}) - $signed({cfg.y[CFG_COORD_W-1], cfg.y});
        // Wrap mode: two conditional subtracts cover DrawX + scroll < 3*w when scroll < w.
        wsum0     = {1'b0, draw_x} + {1'b0, cfg.scroll};
        wsum1     = (wsum0 >= w_ext) ? wsum0 - w_ext : wsum0;
        wsum2     = (wsum1 >= w_ext) ? wsum1 - w_ext : wsum1;
        rx        = cfg.wrap ? $signed(wsum2) : rx_direct;
        in_box_c  = cfg.en && !rx[SW-1] && (rx[SW-1:0] < w_ext)
                           && !ry[SW-1] && (ry[SW-1:0] < h_ext);
        addr_c    = cfg.base;
        if (in_box_c) begin
            addr_c = cfg.base
                   + CFG_ADDR_W'(ry[SW-2:0]) * CFG_ADDR_W'(cfg.stride)
                   + CFG_ADDR_W'(rx[SW-2:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr <= '0;
            in_box  <= 1'b0;
        end else if (pix_en) begin
            rd_addr <= addr_c;
            in_box  <= in_box_c;
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// N-layer compositor: per-layer address gen, priority/transparency resolve,
// shared palette lookup and sync alignment, with per-frame collision report.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int COORD_W    = CFG_COORD_W,
    parameter int ADDR_W     = CFG_ADDR_W,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = TRANSP_IDX_DEFAULT
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          pix_en,
    input  logic [COORD_W-1:0]            DrawX,
    input  logic [COORD_W-1:0]            DrawY,
    input  logic                          blank_in,
    input  logic                          hs_in,
    input  logic                          vs_in,
    input  logic                          frame_start,
    input  logic [NUM_LAYERS*COORD_W-1:0] cfg_x,
    input  logic [NUM_LAYERS*COORD_W-1:0] cfg_y,
    input  logic [NUM_LAYERS*COORD_W-1:0] cfg_w,
    input  logic [NUM_LAYERS*COORD_W-1:0] cfg_h,
    input  logic [NUM_LAYERS*COORD_W-1:0] cfg_stride,
    input  logic [NUM_LAYERS*ADDR_W-1:0]  cfg_base,
    input  logic [NUM_LAYERS*COORD_W-1:0] cfg_scroll,
    input  logic [NUM_LAYERS-1:0]         cfg_en,
    input  logic [NUM_LAYERS-1:0]         cfg_wrap,
    output logic [NUM_LAYERS*ADDR_W-1:0]  rd_addr,
    input  logic [NUM_LAYERS*IDX_W-1:0]   rd_data,
    input  logic                          pal_we,
    input  logic [IDX_W-1:0]              pal_addr,
    input  logic [23:0]                   pal_data,
    input  logic [23:0]                   backdrop,
    output logic [7:0]                    Red,
    output logic [7:0]                    Green,
    output logic [7:0]                    Blue,
    output logic                          hs_out,
    output logic                          vs_out,
    output logic                          blank_out,
    output logic [NUM_LAYERS-1:0]         collide_mask
);

    layer_cfg_t            act [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] in_box;
    logic [NUM_LAYERS-1:0] in_box_d;
    logic [PIPE_LAT-1:0]   blank_d;
    logic [PIPE_LAT-1:0]   hs_d;
    logic [PIPE_LAT-1:0]   vs_d;
    logic [NUM_LAYERS-1:0] opaque;
    logic [NUM_LAYERS-1:0] others;
    logic [NUM_LAYERS-1:0] hit;
    logic [NUM_LAYERS-1:0] acc;
    logic                  found;
    logic [IDX_W-1:0]      win_idx;
    rgb_t                  palette [2**IDX_W];
    rgb_t                  rgb_q;

    // Active config only changes at frame_start so a frame is never torn.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_LAYERS; i++) act[i] <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                act[i].x      <= cfg_x[i*COORD_W +: COORD_W];
                act[i].y      <= cfg_y[i*COORD_W +: COORD_W];
                act[i].w      <= cfg_w[i*COORD_W +: COORD_W];
                act[i].h      <= cfg_h[i*COORD_W +: COORD_W];
                act[i].stride <= cfg_stride[i*COORD_W +: COORD_W];
                act[i].scroll <= cfg_scroll[i*COORD_W +: COORD_W];
                act[i].base   <= cfg_base[i*ADDR_W +: ADDR_W];
                act[i].en     <= cfg_en[i];
                act[i].wrap   <= cfg_wrap[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_LAYERS; g++) begin : g_layer
            layer_addr_gen u_addr_gen (
                .clk     (Clk),
                .reset   (Reset),
                .pix_en  (pix_en),
                .draw_x  (DrawX),
                .draw_y  (DrawY),
                .cfg     (act[g]),
                .rd_addr (rd_addr[g*ADDR_W +: ADDR_W]),
                .in_box  (in_box[g])
            );
        end
    endgenerate

    // in_box_d lines up with rd_data, which trails rd_addr by one tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            in_box_d <= '0;
            blank_d  <= '0;
            hs_d     <= '1;
            vs_d     <= '1;
        end else if (pix_en) begin
            in_box_d <= in_box;
            blank_d  <= {blank_d[PIPE_LAT-2:0], blank_in};
            hs_d     <= {hs_d[PIPE_LAT-2:0], hs_in};
            vs_d     <= {vs_d[PIPE_LAT-2:0], vs_in};
        end
    end

    always_comb begin
        opaque  = '0;
        others  = '0;
        hit     = '0;
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            opaque[i] = in_box_d[i] && (rd_data[i*IDX_W +: IDX_W] != IDX_W'(TRANSP_IDX));
        end
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (opaque[i]) begin
                found   = 1'b1;
                win_idx = rd_data[i*IDX_W +: IDX_W];
            end
            others    = opaque;
            others[i] = 1'b0;
            hit[i]    = opaque[i] && (|others);
        end
    end

    always_ff @(posedge Clk) begin
        if (pal_we) palette[pal_addr] <= pal_data;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rgb_q <= '0;
        end else if (pix_en) begin
            if (!blank_d[PIPE_LAT-2]) rgb_q <= '0;
            else if (found)           rgb_q <= palette[win_idx];
            else                      rgb_q <= backdrop;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc          <= '0;
            collide_mask <= '0;
        end else if (frame_start) begin
            collide_mask <= acc;
            acc          <= '0;
        end else if (pix_en && blank_d[PIPE_LAT-2]) begin
            acc <= acc | hit;
        end
    end

    assign Red       = rgb_q.r;
    assign Green     = rgb_q.g;
    assign Blue      = rgb_q.b;
    assign blank_out = blank_d[PIPE_LAT-1];
    assign hs_out    = hs_d[PIPE_LAT-1];
    assign vs_out    = vs_d[PIPE_LAT-1];

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: addressing, priority, wrap, cfg latching,
// palette write ordering, pix_en hold and mid-frame reset.
module tb_layer_compositor;

    localparam int NL = 4;
    localparam int CW = 10;
    localparam int AW = 19;
    localparam int IW = 4;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            pix_en;
    logic [CW-1:0]   DrawX, DrawY;
    logic            blank_in, hs_in, vs_in, frame_start;
    logic [NL*CW-1:0] cfg_x, cfg_y, cfg_w, cfg_h, cfg_stride, cfg_scroll;
    logic [NL*AW-1:0] cfg_base;
    logic [NL-1:0]   cfg_en, cfg_wrap;
    logic [NL*AW-1:0] rd_addr;
    logic [NL*IW-1:0] rd_data;
    logic            pal_we;
    logic [IW-1:0]   pal_addr;
    logic [23:0]     pal_data;
    logic [23:0]     backdrop;
    logic [7:0]      Red, Green, Blue;
    logic            hs_out, vs_out, blank_out;
    logic [NL-1:0]   collide_mask;

    logic [IW-1:0]   ram [NL][1024];
    int              tests_run = 0;
    int              tests_failed = 0;

    layer_compositor dut (
        .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY),
        .blank_in(blank_in), .hs_in(hs_in), .vs_in(vs_in), .frame_start(frame_start),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .cfg_stride(cfg_stride), .cfg_base(cfg_base), .cfg_scroll(cfg_scroll),
        .cfg_en(cfg_en), .cfg_wrap(cfg_wrap), .rd_addr(rd_addr), .rd_data(rd_data),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data), .backdrop(backdrop),
        .Red(Red), .Green(Green), .Blue(Blue), .hs_out(hs_out), .vs_out(vs_out),
        .blank_out(blank_out), .collide_mask(collide_mask)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    // synchronous sprite RAM model, one tick latency
    always @(posedge Clk) begin
        if (pix_en) begin
            for (int i = 0; i < NL; i++) rd_data[i*IW +: IW] <= ram[i][rd_addr[i*AW +: 10]];
        end
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic set_layer(input int i, input int x, input int y, input int w, input int h,
                             input int stride, input int base, input int scroll,
                             input logic en, input logic wrap);
        cfg_x[i*CW +: CW]      = CW'(x);
        cfg_y[i*CW +: CW]      = CW'(y);
        cfg_w[i*CW +: CW]      = CW'(w);
        cfg_h[i*CW +: CW]      = CW'(h);
        cfg_stride[i*CW +: CW] = CW'(stride);
        cfg_scroll[i*CW +: CW] = CW'(scroll);
        cfg_base[i*AW +: AW]   = AW'(base);
        cfg_en[i]              = en;
        cfg_wrap[i]            = wrap;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(2);
        tests_run++;
        if ({Red, Green, Blue} !== 24'h000000) begin
            tests_failed++; $display("FAIL reset_rgb: got %h expected %h", {Red, Green, Blue}, 24'h0);
        end
        tests_run++;
        if ({blank_out, hs_out, vs_out} !== 3'b011) begin
            tests_failed++; $display("FAIL reset_timing: got %b expected %b", {blank_out, hs_out, vs_out}, 3'b011);
        end
        tests_run++;
        if (collide_mask !== 4'b0000 || rd_addr !== '0) begin
            tests_failed++; $display("FAIL reset_mask_addr: got %b/%h expected 0/0", collide_mask, rd_addr);
        end
        Reset = 1'b0;
        hs_in = 1'b1;
        vs_in = 1'b1;
        for (int k = 0; k < 16; k++) begin
            pal_we   = 1'b1;
            pal_addr = IW'(k);
            pal_data = {8'(16 + k), 8'(32 + k), 8'(48 + k)};
            tick();
        end
        pal_we = 1'b0;
    endtask

    task automatic test_addr();
        set_layer(1, 100, 50, 20, 30, 20, 0, 0, 1'b1, 1'b0);
        ram[1][45] = 4'd7;
        pulse_frame();
        DrawX = 105; DrawY = 52; blank_in = 1'b1;
        tick();
        tests_run++;
        if (rd_addr[1*AW +: AW] !== 19'd45) begin
            tests_failed++; $display("FAIL addr_basic: got %0d expected 45", rd_addr[1*AW +: AW]);
        end
        tick(2);
        tests_run++;
        if ({Red, Green, Blue} !== 24'h172737) begin
            tests_failed++; $display("FAIL rgb_basic: got %h expected %h", {Red, Green, Blue}, 24'h172737);
        end
        DrawX = 119; DrawY = 79;
        tick();
        tests_run++;
        if (rd_addr[1*AW +: AW] !== 19'd599) begin
            tests_failed++; $display("FAIL addr_corner: got %0d expected 599", rd_addr[1*AW +: AW]);
        end
        DrawX = 120;
        tick(3);
        tests_run++;
        if (rd_addr[1*AW +: AW] !== 19'd0 || {Red, Green, Blue} !== 24'h123456) begin
            tests_failed++; $display("FAIL rx_eq_w: got %0d/%h expected 0/123456", rd_addr[1*AW +: AW], {Red, Green, Blue});
        end
        DrawX = 99;
        tick();
        tests_run++;
        if (rd_addr[1*AW +: AW] !== 19'd0) begin
            tests_failed++; $display("FAIL rx_negative: got %0d expected 0", rd_addr[1*AW +: AW]);
        end
    endtask

    task automatic test_priority();
        set_layer(1, 0, 0, 64, 64, 64, 0, 0, 1'b1, 1'b0);
        set_layer(2, 0, 0, 64, 64, 64, 512, 0, 1'b1, 1'b0);
        ram[1][131] = 4'd3;
        ram[2][643] = 4'd5;
        DrawX = 3; DrawY = 2;
        pulse_frame();
        tick(3);
        tests_run++;
        if ({Red, Green, Blue} !== 24'h152535) begin
            tests_failed++; $display("FAIL priority_top: got %h expected %h", {Red, Green, Blue}, 24'h152535);
        end
        pulse_frame();
        tests_run++;
        if (collide_mask !== 4'b0110) begin
            tests_failed++; $display("FAIL collide_mask: got %b expected 0110", collide_mask);
        end
        ram[2][643] = 4'd0;
        tick(3);
        tests_run++;
        if ({Red, Green, Blue} !== 24'h132333) begin
            tests_failed++; $display("FAIL priority_transp: got %h expected %h", {Red, Green, Blue}, 24'h132333);
        end
    endtask

    task automatic test_wrap();
        set_layer(0, 300, 0, 700, 100, 16, 100, 650, 1'b1, 1'b1);
        set_layer(1, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        set_layer(2, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        ram[0][190] = 4'd9;
        pulse_frame();
        DrawX = 60; DrawY = 5;
        tick();
        tests_run++;
        if (rd_addr[0 +: AW] !== 19'd190) begin
            tests_failed++; $display("FAIL wrap_once: got %0d expected 190", rd_addr[0 +: AW]);
        end
        tick(2);
        tests_run++;
        if ({Red, Green, Blue} !== 24'h192939) begin
            tests_failed++; $display("FAIL wrap_rgb: got %h expected %h", {Red, Green, Blue}, 24'h192939);
        end
        DrawX = 760;
        tick();
        tests_run++;
        if (rd_addr[0 +: AW] !== 19'd190) begin
            tests_failed++; $display("FAIL wrap_twice: got %0d expected 190", rd_addr[0 +: AW]);
        end
        DrawX = 40;
        tick();
        tests_run++;
        if (rd_addr[0 +: AW] !== 19'd870) begin
            tests_failed++; $display("FAIL wrap_none: got %0d expected 870", rd_addr[0 +: AW]);
        end
    endtask

    task automatic test_double_buffer();
        set_layer(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        set_layer(1, 100, 0, 20, 20, 20, 0, 0, 1'b1, 1'b0);
        pulse_frame();
        DrawX = 105; DrawY = 1;
        tick();
        tests_run++;
        if (rd_addr[1*AW +: AW] !== 19'd25) begin
            tests_failed++; $display("FAIL dbuf_before: got %0d expected 25", rd_addr[1*AW +: AW]);
        end
        cfg_x[1*CW +: CW] = CW'(200);
        tick(2);
        tests_run++;
        if (rd_addr[1*AW +: AW] !== 19'd25) begin
            tests_failed++; $display("FAIL dbuf_midframe: got %0d expected 25", rd_addr[1*AW +: AW]);
        end
        pulse_frame();
        tick();
        tests_run++;
        if (rd_addr[1*AW +: AW] !== 19'd0) begin
            tests_failed++; $display("FAIL dbuf_old_pos: got %0d expected 0", rd_addr[1*AW +: AW]);
        end
        DrawX = 205;
        tick();
        tests_run++;
        if (rd_addr[1*AW +: AW] !== 19'd25) begin
            tests_failed++; $display("FAIL dbuf_new_pos: got %0d expected 25", rd_addr[1*AW +: AW]);
        end
    endtask

    task automatic test_palette_rw();
        ram[1][25] = 4'd2;
        tick(2);
        tests_run++;
        if ({Red, Green, Blue} !== 24'h122232) begin
            tests_failed++; $display("FAIL pal_initial: got %h expected %h", {Red, Green, Blue}, 24'h122232);
        end
        pal_we = 1'b1; pal_addr = 4'd2; pal_data = 24'hFF0000;
        tick();
        pal_we = 1'b0;
        tests_run++;
        if ({Red, Green, Blue} !== 24'h122232) begin
            tests_failed++; $display("FAIL pal_write_old: got %h expected %h", {Red, Green, Blue}, 24'h122232);
        end
        tick();
        tests_run++;
        if ({Red, Green, Blue} !== 24'hFF0000) begin
            tests_failed++; $display("FAIL pal_write_new: got %h expected %h", {Red, Green, Blue}, 24'hFF0000);
        end
        blank_in = 1'b0; hs_in = 1'b0;
        tick(2);
        tests_run++;
        if ({Red, Green, Blue} !== 24'hFF0000 || blank_out !== 1'b1 || hs_out !== 1'b1) begin
            tests_failed++; $display("FAIL blank_latency: got %h/%b/%b expected ff0000/1/1", {Red, Green, Blue}, blank_out, hs_out);
        end
        tick();
        tests_run++;
        if ({Red, Green, Blue} !== 24'h000000 || blank_out !== 1'b0 || hs_out !== 1'b0) begin
            tests_failed++; $display("FAIL blank_black: got %h/%b/%b expected 000000/0/0", {Red, Green, Blue}, blank_out, hs_out);
        end
        blank_in = 1'b1; hs_in = 1'b1;
        tick(3);
    endtask

    task automatic test_pix_en_hold();
        pix_en = 1'b0;
        DrawX = 105; blank_in = 1'b0;
        tick(4);
        tests_run++;
        if (rd_addr[1*AW +: AW] !== 19'd25 || {Red, Green, Blue} !== 24'hFF0000 || blank_out !== 1'b1) begin
            tests_failed++; $display("FAIL pix_en_hold: got %0d/%h/%b expected 25/ff0000/1", rd_addr[1*AW +: AW], {Red, Green, Blue}, blank_out);
        end
        pix_en = 1'b1; DrawX = 205; blank_in = 1'b1;
        tick(3);
    endtask

    task automatic test_reset_mid();
        set_layer(1, 0, 0, 64, 64, 64, 0, 0, 1'b1, 1'b0);
        set_layer(2, 0, 0, 64, 64, 64, 512, 0, 1'b1, 1'b0);
        ram[2][643] = 4'd5;
        DrawX = 3; DrawY = 2; blank_in = 1'b1;
        pulse_frame();
        tick(4);
        pulse_frame();
        tests_run++;
        if ({Red, Green, Blue} !== 24'h152535 || collide_mask !== 4'b0110) begin
            tests_failed++; $display("FAIL pre_reset: got %h/%b expected 152535/0110", {Red, Green, Blue}, collide_mask);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tests_run++;
        if ({Red, Green, Blue} !== 24'h000000 || blank_out !== 1'b0 || collide_mask !== 4'b0000) begin
            tests_failed++; $display("FAIL mid_reset: got %h/%b/%b expected 000000/0/0000", {Red, Green, Blue}, blank_out, collide_mask);
        end
        tick(2);
        tests_run++;
        if ({Red, Green, Blue} !== 24'h000000) begin
            tests_failed++; $display("FAIL refill_black: got %h expected 000000", {Red, Green, Blue});
        end
        tick();
        tests_run++;
        if ({Red, Green, Blue} !== 24'h123456 || blank_out !== 1'b1) begin
            tests_failed++; $display("FAIL post_reset_backdrop: got %h/%b expected 123456/1", {Red, Green, Blue}, blank_out);
        end
    endtask

    initial begin
        for (int i = 0; i < NL; i++)
            for (int a = 0; a < 1024; a++) ram[i][a] = '0;
        Reset = 1'b1; pix_en = 1'b1; DrawX = '0; DrawY = '0;
        blank_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0; frame_start = 1'b0;
        cfg_x = '0; cfg_y = '0; cfg_w = '0; cfg_h = '0; cfg_stride = '0;
        cfg_scroll = '0; cfg_base = '0; cfg_en = '0; cfg_wrap = '0;
        pal_we = 1'b0; pal_addr = '0; pal_data = '0; backdrop = 24'h123456;

        test_reset();
        test_addr();
        test_priority();
        test_wrap();
        test_double_buffer();
        test_palette_rw();
        test_pix_en_hold();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised N-layer pixel compositor. Generalises the fixed mario, background and brick sprite-RAM/palette wiring into one block.
- Per layer: generates the sprite/tile RAM read address from DrawX/DrawY, the layer position, size, stride and scroll.
- Resolves transparency and priority across layers, looks up a shared writable palette, and emits registered 8-bit RGB aligned with delayed sync/blank.
- Sits between vga_controller and the VGA pins.

Parameters:
- NUM_LAYERS, 4, number of layers; layer NUM_LAYERS-1 is on top.
- COORD_W, 10, width of screen coordinates, sizes and scroll values.
- ADDR_W, 19, sprite RAM address width.
- IDX_W, 4, palette index width; palette has 2^IDX_W entries.
- TRANSP_IDX, 0, palette index treated as transparent.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high reset.
- pix_en  in  1  pixel-clock enable; the pipeline advances only when high.
- DrawX, DrawY  in  COORD_W each  current pixel from vga_controller.
- blank_in, hs_in, vs_in  in  1 each  timing from vga_controller. blank_in high means active video.
- frame_start  in  1  one-Clk pulse at start of vertical blank.
- cfg_x, cfg_y  in  NUM_LAYERS*COORD_W each  layer top-left, signed.
- cfg_w, cfg_h, cfg_stride  in  NUM_LAYERS*COORD_W each  layer size and RAM row stride.
- cfg_base  in  NUM_LAYERS*ADDR_W  layer RAM base address.
- cfg_scroll  in  NUM_LAYERS*COORD_W  horizontal scroll offset.
- cfg_en, cfg_wrap  in  NUM_LAYERS each  per-layer enable and horizontal-wrap mode.
- rd_addr  out  NUM_LAYERS*ADDR_W  per-layer RAM read address.
- rd_data  in  NUM_LAYERS*IDX_W  per-layer RAM data; synchronous read, 1 pix_en tick latency.
- pal_we  in  1  palette write enable.
- pal_addr  in  IDX_W  palette write address.
- pal_data  in  24  palette write data, {R,G,B}.
- backdrop  in  24  colour shown when no layer is opaque.
- Red, Green, Blue  out  8 each  composited colour.
- hs_out, vs_out, blank_out  out  1 each  timing delayed to match RGB.
- collide_mask  out  NUM_LAYERS  previous frame's layers that overlapped another opaque layer.

Behaviour:
- Config double-buffering: all cfg_* inputs are copied into active registers only on a Clk where frame_start=1. Values present on that cycle are taken. Mid-frame cfg changes have no visible effect.
- Pipeline: 3 pix_en ticks, DrawX/DrawY to Red/Green/Blue. hs/vs/blank are delayed by the same 3 ticks. With pix_en low, all stages hold.
- S0, address stage:
  - rx = DrawX - x and ry = DrawY - y, computed in COORD_W+1 signed arithmetic.
  - If wrap=1: rx = (DrawX + scroll) mod w, via a subtract loop of at most 2 iterations (scroll < w is required), and x is ignored.
  - in_box = en & 0<=rx<w & 0<=ry<h.
  - rd_addr = base + ry*stride + rx, truncated to ADDR_W. When in_box=0, rd_addr = base.
  - in_box is registered alongside.
- S1, data stage: opaque[i] = in_box[i] & (rd_data[i] != TRANSP_IDX). The winner is the highest i with opaque set. If none, the backdrop is selected.
- S2, palette stage: registered palette read of the winner's index. The output is the palette colour or backdrop; 0 when delayed blank is low.
- Palette: 2^IDX_W x 24 registers. A write on the same Clk as a read of the same address returns the old data. Reset does not clear the palette.
- Collision:
  - A sticky accumulator sets bit i when opaque[i] and any other opaque[j] are both high during active video.
  - On frame_start: collide_mask <= accumulator, and the accumulator clears. The clear wins over a set on the same Clk.
- Reset values:
  - All active cfg registers 0, so all layers are disabled.
  - Pipeline valid/timing registers: blank_out=0, hs_out=1, vs_out=1.
  - RGB=0, rd_addr=0, collide_mask=0, accumulator=0.
- Reset mid-frame: output is backdrop-free black (blanked) until the pipeline refills. Layers stay disabled until the next frame_start.
- Negative x/y (partly off-screen sprites) are handled by the signed compare. rx >= w is never in_box.

Decomposition:
- Package compositor_pkg holds:
  - the layer_cfg_t struct (x, y, w, h, stride, base, scroll, en, wrap);
  - rgb_t;
  - the constants PIPE_LAT=3 and TRANSP_IDX default.
- Sub-module layer_addr_gen: one instance per layer, generate loop. Contains the S0 arithmetic and the in_box register.

Test Plan:
1. Layer 1 at (100,50), w=20, h=30, stride 20, base 0, en=1; DrawX=105, DrawY=52 → rd_addr[1]=45. RGB equals palette[rd_data] three ticks later.
2. Layers 1 and 2 both opaque at the same pixel (indices 3 and 5) → RGB = palette[5]. With layer 2 index = TRANSP_IDX → palette[3]. After frame_start, collide_mask = 4'b0110 in the first case.
3. Layer 0 wrap=1, w=700, scroll=650; DrawX=60 → rx=10, rd_addr[0] = base + DrawY*stride + 10.
4. Change cfg_x mid-frame from 100 to 200 → rd_addr unchanged until frame_start pulses, then reflects 200.
5. pal_we to addr 2 with 24'hFF0000 while reading index 2 → old colour that tick, red on the next. blank_in low → RGB=0.
6. Assert Reset mid-line → next Clk: RGB=0, blank_out=0, collide_mask=0. After release, with no frame_start, output = backdrop during active video.
